// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a NUM_REGS x 8 register file to an I2C master and a local host port.
// Bus lines are synchronised and glitch-filtered; protocol handling runs entirely on clk.
`timescale 1ns/1ps

module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h55,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       start_rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_idx,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int         CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_IDX, ST_WRITE, ST_READ, ST_WAIT_STOP
    } state_t;

    logic [1:0] raw_in;
    logic [1:0] filt;
    logic [1:0] filt_prev_reg;

    assign raw_in = {sda_i, scl_i};

    // Bit 0 is SCL, bit 1 is SDA; each line gets its own synchroniser and filter.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filter
            logic          sync1_reg, sync2_reg, filt_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge start_rst) begin
                if (start_rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                        filt_reg <= sync2_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    logic scl_f, sda_f, scl_prev, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_prev  = filt_prev_reg[0];
    assign sda_prev  = filt_prev_reg[1];
    assign scl_rise  = scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f & scl_prev;
    assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

    state_t     state_reg;
    logic [3:0] bit_cnt_reg;
    logic       rose_reg;
    logic [7:0] rx_reg;
    logic [6:0] tx_reg;
    logic [7:0] ptr_reg;
    logic       mack_reg;
    logic       sda_oe_reg;
    logic       wr_strobe_reg;
    logic [7:0] wr_idx_reg, wr_data_reg;

    logic       byte_done;
    logic       i2c_we;
    logic [7:0] ptr_wrap;
    logic [7:0] ptr_data;
    logic [7:0] regs [NUM_REGS];

    // A bit only counts once its SCL high phase has been seen, so the START's own SCL fall is skipped.
    assign byte_done = scl_fall & rose_reg & (bit_cnt_reg == 4'd7);
    assign i2c_we    = byte_done & (state_reg == ST_WRITE);
    assign ptr_wrap  = (ptr_reg == LAST_IDX) ? 8'd0 : ptr_reg + 8'd1;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            logic [7:0] r_reg;

            // The I2C write takes priority when both ports hit the same index.
            always_ff @(posedge clk or posedge start_rst) begin
                if (start_rst) begin
                    r_reg <= 8'h00;
                end else if (i2c_we && ptr_reg == 8'(gi)) begin
                    r_reg <= rx_reg;
                end else if (host_we && host_addr == 8'(gi)) begin
                    r_reg <= host_wdata;
                end
            end

            assign regs[gi] = r_reg;
        end
    endgenerate

    always_comb begin
        host_rdata = 8'h00;
        ptr_data   = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (host_addr == 8'(i)) host_rdata = regs[i];
            if (ptr_reg == 8'(i))   ptr_data   = regs[i];
        end
    end

    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            filt_prev_reg <= 2'b11;
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 4'd0;
            rose_reg      <= 1'b0;
            rx_reg        <= 8'h00;
            tx_reg        <= 7'h00;
            ptr_reg       <= 8'h00;
            mack_reg      <= 1'b0;
            sda_oe_reg    <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_idx_reg    <= 8'h00;
            wr_data_reg   <= 8'h00;
        end else begin
            filt_prev_reg <= filt;
            wr_strobe_reg <= 1'b0;
            if (start_det) begin
                state_reg   <= ST_ADDR;
                bit_cnt_reg <= 4'd0;
                rose_reg    <= 1'b0;
                sda_oe_reg  <= 1'b0;
            end else if (stop_det) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= 4'd0;
                rose_reg    <= 1'b0;
                sda_oe_reg  <= 1'b0;
            end else if (state_reg != ST_IDLE) begin
                if (scl_rise) begin
                    rose_reg <= 1'b1;
                    if (bit_cnt_reg < 4'd8) begin
                        rx_reg <= {rx_reg[6:0], sda_f};
                    end else if (state_reg == ST_READ && !sda_oe_reg) begin
                        mack_reg <= ~sda_f;
                    end
                end else if (scl_fall && rose_reg) begin
                    rose_reg <= 1'b0;
                    if (bit_cnt_reg == 4'd7) begin
                        bit_cnt_reg <= 4'd8;
                        case (state_reg)
                            ST_ADDR: begin
                                if (rx_reg[7:1] == DEV_ADDR) begin
                                    sda_oe_reg <= 1'b1;
                                    mack_reg   <= 1'b1;
                                    state_reg  <= rx_reg[0] ? ST_READ : ST_IDX;
                                end else begin
                                    state_reg <= ST_IDLE;
                                end
                            end
                            ST_IDX: begin
                                if ({1'b0, rx_reg} < 9'(NUM_REGS)) begin
                                    sda_oe_reg <= 1'b1;
                                    ptr_reg    <= rx_reg;
                                    state_reg  <= ST_WRITE;
                                end else begin
                                    state_reg <= ST_WAIT_STOP;
                                end
                            end
                            ST_WRITE: begin
                                sda_oe_reg    <= 1'b1;
                                wr_strobe_reg <= 1'b1;
                                wr_idx_reg    <= ptr_reg;
                                wr_data_reg   <= rx_reg;
                                ptr_reg       <= ptr_wrap;
                            end
                            ST_READ: begin
                                sda_oe_reg <= 1'b0;
                                ptr_reg    <= ptr_wrap;
                            end
                            default: ;
                        endcase
                    end else if (bit_cnt_reg == 4'd8) begin
                        bit_cnt_reg <= 4'd0;
                        if (state_reg == ST_READ && mack_reg) begin
                            tx_reg     <= ptr_data[6:0];
                            sda_oe_reg <= ~ptr_data[7];
                        end else begin
                            sda_oe_reg <= 1'b0;
                            if (state_reg == ST_READ) state_reg <= ST_WAIT_STOP;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (state_reg == ST_READ) begin
                            sda_oe_reg <= ~tx_reg[6];
                            tx_reg     <= {tx_reg[5:0], 1'b0};
                        end
                    end
                end
            end
        end
    end

    assign sda_oe    = sda_oe_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_idx    = wr_idx_reg;
    assign wr_data   = wr_data_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h55, 7-bit slave address matched against the address byte.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count, legal range 1..256.
REQ-003 SHALL have parameter FILTER_LEN, default 3, number of consecutive equal clk samples required to accept a new SCL/SDA level.
REQ-004 SHALL have port clk input 1, system clock; all logic SHALL be synchronous to posedge clk.
REQ-005 SHALL have port start_rst input 1, reset, asynchronous, active-high.
REQ-006 SHALL have port scl_i input 1, raw I2C clock from the pad.
REQ-007 SHALL have port sda_i input 1, raw I2C data from the pad.
REQ-008 SHALL have port sda_oe output 1, 1 = pull SDA low, 0 = release (open drain).
REQ-009 SHALL have port host_we input 1, local write enable.
REQ-010 SHALL have port host_addr input 8, local register index.
REQ-011 SHALL have port host_wdata input 8, local write data.
REQ-012 SHALL have port host_rdata output 8, combinational read of reg[host_addr]; 8'h00 when host_addr >= NUM_REGS.
REQ-013 SHALL have port wr_strobe output 1, one-clk pulse per I2C-written byte.
REQ-014 SHALL have port wr_idx output 8, index of the byte written, valid with wr_strobe.
REQ-015 SHALL have port wr_data output 8, data written, valid with wr_strobe.
REQ-016 SHALL have port busy output 1, high from an accepted START to STOP or return to IDLE.

Function
REQ-017 scl_i/sda_i SHALL pass a 2-FF synchroniser, then a filter that changes its output only after FILTER_LEN consecutive equal samples.
REQ-018 START SHALL be filtered SDA 1->0 while filtered SCL high; STOP SHALL be SDA 0->1 while SCL high; both are one-clk internal pulses.
REQ-019 Data SHALL be sampled on the filtered SCL rising edge, MSB first; slave-driven bits SHALL change on the clk after a filtered SCL falling edge.
REQ-020 A bit counter SHALL count 0..8 per byte (8 data + ACK) and SHALL clear on START and after bit 8.
REQ-021 States SHALL be IDLE, ADDR, IDX, WRITE, READ, WAIT_STOP.
REQ-022 START from any state, including a repeated START, SHALL enter ADDR.
REQ-023 ADDR: on address mismatch -> IDLE with no ACK; on match with R/W=0 -> ACK, then IDX; on match with R/W=1 -> ACK, then READ.
REQ-024 IDX: index < NUM_REGS -> ACK, load pointer, -> WRITE; index >= NUM_REGS -> NACK, -> WAIT_STOP.
REQ-025 WRITE: each byte SHALL be ACKed, stored in reg[pointer], and pulse wr_strobe/wr_idx/wr_data on the clk the ACK drive begins.
REQ-026 READ: reg[pointer] SHALL be loaded into the output shifter at the first SCL fall of a byte; master ACK -> next byte; master NACK -> WAIT_STOP.
REQ-027 The pointer SHALL increment after every transferred data byte and wrap NUM_REGS-1 -> 0.
REQ-028 The pointer SHALL persist across STOP and repeated START, so an address-only read continues from the last pointer.
REQ-029 STOP in any state SHALL -> IDLE, release sda_oe and deassert busy.
REQ-030 sda_oe SHALL be asserted only during a slave ACK bit or a read data bit equal to 0; it SHALL never change while filtered SCL is high, except on release at STOP/START.
REQ-031 If host_we and an I2C write target the same index in the same clk, the I2C write SHALL win; different indices SHALL both complete.
REQ-032 host_we with host_addr >= NUM_REGS SHALL be ignored.

Reset
REQ-033 start_rst SHALL immediately force sda_oe=0, wr_strobe=0, busy=0, state=IDLE, pointer=0, bit counter=0, every reg=8'h00, and filter outputs=1.
REQ-034 Assertion mid-transfer SHALL abort the transfer; after release, the block SHALL ignore the bus until the next START.

Verification
REQ-035 Write: START, 0xAA, 0x03, 0x57, STOP -> three ACKs; wr_strobe once with wr_idx=3, wr_data=0x57; host_rdata@3=0x57.
REQ-036 Read: after REQ-035, START, 0xAA, 0x03, RESTART, 0xAB, then master reads and NACKs -> slave returns 0x57, and the pointer equals 4 after STOP.
REQ-037 Burst with wrap: NUM_REGS=4, write index 3 with 0x11, 0x22 -> reg3=0x11, reg0=0x22, two wr_strobe pulses.
REQ-038 Address mismatch and bad index: 0xA8 -> NACK, busy drops; 0xAA, 0x10 with NUM_REGS=16 -> address ACKed, index NACKed, no writes.
REQ-039 Glitch and reset: a 1-clk SCL glitch with FILTER_LEN=3 -> no bit counted; start_rst during the data byte -> sda_oe=0 at once and all regs read 0x00.
